// File: rtl/risc_ctrl_fsm_pkg.sv
// Shared encodings for the RISC control FSM: state codes, instruction fields,
// register-select and write-back source constants.
package risc_ctrl_fsm_pkg;

    localparam int NSEL_W = 3;

    typedef logic [2:0] state_t;

    localparam state_t S_WAIT      = 3'd0;
    localparam state_t S_DECODE    = 3'd1;
    localparam state_t S_WRITE_IMM = 3'd2;
    localparam state_t S_GET_A     = 3'd3;
    localparam state_t S_GET_B     = 3'd4;
    localparam state_t S_ALU       = 3'd5;
    localparam state_t S_WRITE_REG = 3'd6;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MOVIMM  = 2'b10;
    localparam logic [1:0] OP_MOVREG  = 2'b00;

    localparam logic [NSEL_W-1:0] NSEL_NONE = 3'b000;
    localparam logic [NSEL_W-1:0] NSEL_RN   = 3'b001;
    localparam logic [NSEL_W-1:0] NSEL_RD   = 3'b010;
    localparam logic [NSEL_W-1:0] NSEL_RM   = 3'b100;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b01;

    // First state after DECODE; S_WAIT marks an illegal encoding.
    function automatic state_t dispatch(input logic [2:0] opc, input logic [1:0] op);
        state_t nxt;
        nxt = S_WAIT;
        if (opc == OPC_MOV) begin
            if (op == OP_MOVIMM)      nxt = S_WRITE_IMM;
            else if (op == OP_MOVREG) nxt = S_GET_B;
        end else if (opc == OPC_ALU) begin
            if (op == OP_MVN) nxt = S_GET_B;
            else              nxt = S_GET_A;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/risc_ctrl_fsm.sv
// Moore control FSM sequencing register-file reads, ALU execute and
// write-back for the 16-bit RISC datapath.
//
// state       | meaning
// WAIT        | idle, w=1, samples s
// DECODE      | opcode/op latched, dispatch (err on illegal)
// WRITE_IMM   | write sximm8 into Rn
// GET_A       | read Rn into A
// GET_B       | read Rm into B
// ALU         | execute; CMP loads status and finishes here
// WRITE_REG   | write C into Rd
module risc_ctrl_fsm
    import risc_ctrl_fsm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic [2:0]        opcode,
    input  logic [1:0]        op,
    output logic [NSEL_W-1:0] nsel,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              asel,
    output logic              bsel,
    output logic              loadc,
    output logic              loads,
    output logic [1:0]        vsel,
    output logic              w,
    output logic              done,
    output logic              err
);

    state_t     state_q, state_d;
    logic [2:0] opc_q, opc_d;
    logic [1:0] op_q, op_d;
    logic       is_cmp;
    logic       is_neg_path;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            opc_q   <= 3'b000;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            op_q    <= op_d;
        end
    end

    assign is_cmp      = (opc_q == OPC_ALU) && (op_q == OP_CMP);
    // MOV-reg and MVN pass B through the ALU with A forced to zero.
    assign is_neg_path = ((opc_q == OPC_MOV) && (op_q == OP_MOVREG)) ||
                         ((opc_q == OPC_ALU) && (op_q == OP_MVN));

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        op_d    = op_q;
        case (state_q)
            S_WAIT: begin
                if (s) begin
                    state_d = S_DECODE;
                    opc_d   = opcode;
                    op_d    = op;
                end
            end
            S_DECODE:    state_d = dispatch(opc_q, op_q);
            S_WRITE_IMM: state_d = S_WAIT;
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_ALU;
            S_ALU:       state_d = is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    always_comb begin
        nsel  = NSEL_NONE;
        write = 1'b0;
        loada = 1'b0;
        loadb = 1'b0;
        asel  = 1'b0;
        bsel  = 1'b0;
        loadc = 1'b0;
        loads = 1'b0;
        vsel  = VSEL_C;
        w     = 1'b0;
        done  = 1'b0;
        err   = 1'b0;
        case (state_q)
            S_WAIT:   w = 1'b1;
            S_DECODE: err = (dispatch(opc_q, op_q) == S_WAIT);
            S_WRITE_IMM: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM;
                write = 1'b1;
                done  = 1'b1;
            end
            S_GET_A: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            S_GET_B: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            S_ALU: begin
                asel  = is_neg_path;
                loads = is_cmp;
                loadc = !is_cmp;
                done  = is_cmp;
            end
            S_WRITE_REG: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// Directed bench for risc_ctrl_fsm: per-state output vectors checked cycle by
// cycle against hand-built expectations, plus always-on strobe invariants.
module tb_risc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] nsel;
    logic       write, loada, loadb, asel, bsel, loadc, loads, w, done, err;
    logic [1:0] vsel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    risc_ctrl_fsm dut (
        .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
        .nsel(nsel), .write(write), .loada(loada), .loadb(loadb),
        .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads),
        .vsel(vsel), .w(w), .done(done), .err(err)
    );

    // {nsel[14:12], write, loada, loadb, asel, bsel, loadc, loads, vsel[4:3], w, done, err}
    logic [14:0] outs;
    assign outs = {nsel, write, loada, loadb, asel, bsel, loadc, loads, vsel, w, done, err};

    localparam logic [14:0] E_WAIT    = 15'b000_0_0_0_0_0_0_0_00_1_0_0;
    localparam logic [14:0] E_DEC     = 15'b000_0_0_0_0_0_0_0_00_0_0_0;
    localparam logic [14:0] E_DEC_ERR = 15'b000_0_0_0_0_0_0_0_00_0_0_1;
    localparam logic [14:0] E_WIMM    = 15'b001_1_0_0_0_0_0_0_01_0_1_0;
    localparam logic [14:0] E_GETA    = 15'b001_0_1_0_0_0_0_0_00_0_0_0;
    localparam logic [14:0] E_GETB    = 15'b100_0_0_1_0_0_0_0_00_0_0_0;
    localparam logic [14:0] E_ALU     = 15'b000_0_0_0_0_0_1_0_00_0_0_0;
    localparam logic [14:0] E_ALU_NEG = 15'b000_0_0_0_1_0_1_0_00_0_0_0;
    localparam logic [14:0] E_ALU_CMP = 15'b000_0_0_0_0_0_0_1_00_0_1_0;
    localparam logic [14:0] E_WREG    = 15'b010_1_0_0_0_0_0_0_00_0_1_0;

    // Invariants sampled on the falling edge while out of reset.
    logic prev_write = 1'b0;
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            checks++;
            if (prev_write && write) begin
                errors++;
                $display("FAIL write_consecutive: write=%b two cycles running, required not", write);
            end
            checks++;
            if ((32'(loada) + 32'(loadb) + 32'(loadc) + 32'(write)) > 1) begin
                errors++;
                $display("FAIL strobe_exclusive: loada=%b loadb=%b loadc=%b write=%b, required at most one",
                         loada, loadb, loadc, write);
            end
        end
        prev_write = write;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; s = 1'b0; opcode = 3'b000; op = 2'b00;
        tick();
        tick();
        checks++;
        if (outs !== E_WAIT) begin
            errors++;
            $display("FAIL reset_state: outs=%b required=%b", outs, E_WAIT);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (outs !== E_WAIT) begin
                errors++;
                $display("FAIL idle_wait[%0d]: outs=%b required=%b", i, outs, E_WAIT);
            end
        end
    endtask

    task automatic test_mov_imm();
        logic [14:0] exp [3];
        exp = '{E_DEC, E_WIMM, E_WAIT};
        opcode = 3'b110; op = 2'b10; s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            s = 1'b0;
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL mov_imm[%0d]: outs=%b required=%b", i, outs, exp[i]);
            end
        end
    endtask

    task automatic test_add_and_mid_change();
        logic [14:0] exp [6];
        int writes;
        exp = '{E_DEC, E_GETA, E_GETB, E_ALU, E_WREG, E_WAIT};
        writes = 0;
        opcode = 3'b101; op = 2'b00; s = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            s = 1'b0;
            opcode = 3'b110; op = 2'b10;
            if (write) writes++;
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL add[%0d]: outs=%b required=%b", i, outs, exp[i]);
            end
        end
        checks++;
        if (writes !== 1) begin
            errors++;
            $display("FAIL add_write_count: got=%0d required=1", writes);
        end
    endtask

    task automatic test_and_movreg();
        logic [14:0] exp_and [6];
        logic [14:0] exp_mov [5];
        exp_and = '{E_DEC, E_GETA, E_GETB, E_ALU, E_WREG, E_WAIT};
        exp_mov = '{E_DEC, E_GETB, E_ALU_NEG, E_WREG, E_WAIT};
        opcode = 3'b101; op = 2'b10; s = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            s = 1'b0;
            checks++;
            if (outs !== exp_and[i]) begin
                errors++;
                $display("FAIL and[%0d]: outs=%b required=%b", i, outs, exp_and[i]);
            end
        end
        opcode = 3'b110; op = 2'b00; s = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            s = 1'b0;
            checks++;
            if (outs !== exp_mov[i]) begin
                errors++;
                $display("FAIL mov_reg[%0d]: outs=%b required=%b", i, outs, exp_mov[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] exp [10];
        int cmp_writes;
        exp = '{E_DEC, E_GETA, E_GETB, E_ALU_CMP, E_WAIT,
                E_DEC, E_GETB, E_ALU_NEG, E_WREG, E_WAIT};
        cmp_writes = 0;
        opcode = 3'b101; op = 2'b01; s = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) op = 2'b11;
            if (i == 8) s = 1'b0;
            if (i < 4 && write) cmp_writes++;
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL b2b[%0d]: outs=%b required=%b", i, outs, exp[i]);
            end
        end
        checks++;
        if (cmp_writes !== 0) begin
            errors++;
            $display("FAIL cmp_write_count: got=%0d required=0", cmp_writes);
        end
        tick();
        checks++;
        if (outs !== E_WAIT) begin
            errors++;
            $display("FAIL b2b_idle: outs=%b required=%b", outs, E_WAIT);
        end
    endtask

    task automatic test_illegal();
        logic [4:0] vec [4];
        vec = '{5'b000_00, 5'b110_01, 5'b110_11, 5'b111_10};
        for (int k = 0; k < 4; k++) begin
            opcode = vec[k][4:2]; op = vec[k][1:0]; s = 1'b1;
            tick();
            s = 1'b0;
            checks++;
            if (outs !== E_DEC_ERR) begin
                errors++;
                $display("FAIL illegal_decode[%0d]: outs=%b required=%b", k, outs, E_DEC_ERR);
            end
            tick();
            checks++;
            if (outs !== E_WAIT) begin
                errors++;
                $display("FAIL illegal_return[%0d]: outs=%b required=%b", k, outs, E_WAIT);
            end
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        opcode = 3'b101; op = 2'b00; s = 1'b1;
        tick();
        s = 1'b0;
        tick();
        tick();
        checks++;
        if (outs !== E_GETB) begin
            errors++;
            $display("FAIL rst_mid_getb: outs=%b required=%b", outs, E_GETB);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (outs !== E_WAIT) begin
            errors++;
            $display("FAIL rst_mid_wait: outs=%b required=%b", outs, E_WAIT);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (loadc || write || done || !w) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rst_mid_quiet: bad_cycles=%0d required=0", bad);
        end
        // Reset during WRITE_REG keeps write for that cycle only.
        opcode = 3'b101; op = 2'b00; s = 1'b1;
        tick();
        s = 1'b0;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        #1;
        checks++;
        if (outs !== E_WREG) begin
            errors++;
            $display("FAIL rst_wreg_hold: outs=%b required=%b", outs, E_WREG);
        end
        tick();
        reset = 1'b0;
        checks++;
        if (outs !== E_WAIT) begin
            errors++;
            $display("FAIL rst_wreg_drop: outs=%b required=%b", outs, E_WAIT);
        end
    endtask

    initial begin
        reset = 1'b1; s = 1'b0; opcode = 3'b000; op = 2'b00;
        test_reset();
        test_mov_imm();
        test_add_and_mid_change();
        test_and_movreg();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/risc_ctrl_fsm.md
Name: risc_ctrl_fsm

Overview:
Moore-style control FSM that sequences the 16-bit, 8-entry register file and the ALU datapath of the RISC machine. It accepts a start pulse and the decoded opcode/op fields from the instruction register. It then walks through the read-A, read-B, execute and write-back steps, driving the register-file select/write strobes and the datapath load enables. It sits between the instruction register/decoder and the datapath and is the only agent that asserts the register-file write strobe.

Parameters:
NSEL_W, 3, width of the one-hot register-select bus (fixed at 3: Rn/Rd/Rm)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
s  input  1  start; sampled only in WAIT
opcode  input  3  instruction opcode field
op  input  2  instruction op field
nsel  output  3  one-hot register-field select to readnum/writenum mux: 001=Rn, 010=Rd, 100=Rm, 000=none
write  output  1  register-file write strobe
loada  output  1  load datapath A register
loadb  output  1  load datapath B register
asel  output  1  1 = force ALU A input to zero
bsel  output  1  1 = ALU B input from sximm5 (always 0 in this ISA subset)
loadc  output  1  load result register C
loads  output  1  load status flags
vsel  output  2  write-back source: 00=C, 01=sximm8, 1x reserved (never driven)
w  output  1  1 = idle/ready for next instruction
done  output  1  one-cycle pulse on last state of a legal instruction
err  output  1  one-cycle pulse when an illegal opcode/op is decoded

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high.
- Reset: at the clk edge with reset=1, state <= WAIT and the latched opcode/op are cleared.
  - Outputs after reset: w=1; all others 0; nsel=000; vsel=00.
  - Reset overrides s and any in-flight instruction.
- Outputs are a pure function of the current state (Moore).
  - If reset is asserted during WRITE_REG, write stays 1 for that cycle. It drops at the edge.
- States (encoding goes in the package):
  - WAIT: w=1.
  - DECODE: all strobes 0. opcode/op captured into internal registers at the edge entering DECODE.
  - WRITE_IMM: nsel=001, vsel=01, write=1, done=1.
  - GET_A: nsel=001, loada=1.
  - GET_B: nsel=100, loadb=1.
  - ALU: loadc=1. asel=1 for MOV-reg/MVN. loads=1 for CMP only; for CMP, done=1 here and loadc=0.
  - WRITE_REG: nsel=010, vsel=00, write=1, done=1.
- Transitions:
  - WAIT -> DECODE when s=1, else stay. s in any other state is ignored.
  - DECODE dispatch on the latched {opcode,op}:
    - 110_10 (MOV Rn,#imm8) -> WRITE_IMM
    - 110_00 (MOV Rd,Rm) -> GET_B
    - 101_00 (ADD), 101_01 (CMP), 101_10 (AND) -> GET_A
    - 101_11 (MVN) -> GET_B
    - anything else -> WAIT, with err=1 during DECODE.
  - GET_A -> GET_B -> ALU.
  - ALU -> WAIT for CMP; otherwise ALU -> WRITE_REG.
  - WRITE_IMM -> WAIT and WRITE_REG -> WAIT.
- Latency: w low from the edge after s is sampled.
  - MOV imm: busy 2 cycles.
  - MOV reg / MVN: busy 4 cycles.
  - ADD / AND: busy 5 cycles.
  - CMP: busy 4 cycles.
  - Illegal: busy 1 cycle.
- Inputs opcode/op may change after the DECODE edge with no effect on the in-flight instruction.
- s held high continuously starts back-to-back instructions, with exactly one WAIT cycle between them.
- write is never asserted in two consecutive cycles.
- At most one of loada/loadb/loadc/write is high in any cycle.

Decomposition:
- Shared package holds:
  - state enum: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG (3-bit)
  - opcode/op localparams: OPC_MOV=3'b110, OPC_ALU=3'b101, OP_ADD/CMP/AND/MVN, OP_MOVIMM=2'b10, OP_MOVREG=2'b00
  - nsel constants: NSEL_RN/RD/RM
  - vsel constants: VSEL_C/VSEL_IMM
- No sub-module. Write state register, next-state logic and output decode within the one module.

Test Plan:
- Reset and idle: reset=1 for 1 cycle from an arbitrary state -> w=1, all strobes 0. With s=0 for 10 cycles, state stays in WAIT.
- MOV Rn,#imm8: opcode=110, op=10, s pulse -> DECODE, then WRITE_IMM with nsel=001, vsel=01, write=1, done=1. w=1 on the 3rd cycle after the s edge.
- ADD: opcode=101, op=00 -> sequence is:
  - loada with nsel=001
  - loadb with nsel=100
  - loadc with asel=0, loads=0
  - write with nsel=010, vsel=00
  - Exactly 1 write pulse; w returns after 5 busy cycles.
- CMP then MVN back-to-back with s held high:
  - CMP: loads=1 in ALU and write never asserted.
  - MVN: GET_B, then ALU with asel=1, then WRITE_REG.
  - Exactly 1 WAIT cycle between the two instructions.
- Illegal and mid-op changes:
  - opcode=000 -> err=1 for 1 cycle in DECODE, no strobes, back in WAIT next cycle.
  - Changing opcode during an ADD after DECODE does not alter the sequence.
- Reset mid-instruction: reset asserted during GET_B of an ADD -> WAIT at the next edge, no loadc and no write ever issued, done=0.
